vedic_barrett: RTL and testbench



---
 rtl/vedic_barrett.sv | 116 +++++++++++
 tb/tb_vedic_barrett.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vedic_barrett.sv
// Four-stage pipelined Barrett modular multiplier, t = (a*b) mod q, with q/mu/k
// carried alongside their operands so the modulus may change every cycle.

module vedic_mul #(
    parameter int N = 64
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    // Urdhva-Tiryakbhyam: 2x2 leaf, larger sizes from four half-width products.
    generate
        if (N == 2) begin : g_base
            logic c1;
            assign p[0] = a[0] & b[0];
            assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
            assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
            assign p[2] = (a[1] & b[1]) ^ c1;
            assign p[3] = (a[1] & b[1]) & c1;
        end else begin : g_rec
            localparam int H = N / 2;
            logic [N-1:0] ll, lh, hl, hh;
            vedic_mul #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
            vedic_mul #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh));
            vedic_mul #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl));
            vedic_mul #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));
            assign p = {hh, ll}
                     + {{H{1'b0}}, lh, {H{1'b0}}}
                     + {{H{1'b0}}, hl, {H{1'b0}}};
        end
    endgenerate
endmodule

module vedic_barrett (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [63:0] q,
    input  logic [30:0] mu,
    input  logic [7:0]  k,
    output logic [63:0] t
);
    logic [127:0] prod1, prod2, prod3;
    logic [127:0] q1_full, q3_full;
    logic [8:0]   sh1, sh3;
    logic [65:0]  r_next, q_ext, r_fix1, r_fix2;

    logic [127:0] x_s1;
    logic [63:0]  q_s1;
    logic [30:0]  mu_s1;
    logic [7:0]   k_s1;

    logic [65:0]  x_s2;
    logic [127:0] q2_s2;
    logic [63:0]  q_s2;
    logic [7:0]   k_s2;

    logic [65:0]  r_s3;
    logic [63:0]  q_s3;

    vedic_mul #(.N(64)) u_mul_ab (.a(a), .b(b), .p(prod1));

    // 9-bit shift amounts keep k=0 and k=255 deterministic instead of wrapping.
    assign sh1     = {1'b0, k_s1} - 9'd1;
    assign q1_full = x_s1 >> sh1;

    vedic_mul #(.N(64)) u_mul_mu (.a(q1_full[63:0]), .b({33'd0, mu_s1}), .p(prod2));

    assign sh3     = {1'b0, k_s2} + 9'd1;
    assign q3_full = q2_s2 >> sh3;

    vedic_mul #(.N(64)) u_mul_q (.a(q3_full[63:0]), .b(q_s2), .p(prod3));

    assign r_next = x_s2 - prod3[65:0];
    assign q_ext  = {2'b00, q_s3};

    // r is below 3q, so at most two conditional subtractions are needed.
    always_comb begin
        r_fix1 = r_s3;
        if (r_s3 >= q_ext) r_fix1 = r_s3 - q_ext;
        r_fix2 = r_fix1;
        if (r_fix1 >= q_ext) r_fix2 = r_fix1 - q_ext;
    end

    logic unused_bits;
    assign unused_bits = ^{q3_full[127:64], prod3[127:66], r_fix2[65:64]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_s1  <= '0;
            q_s1  <= '0;
            mu_s1 <= '0;
            k_s1  <= '0;
            x_s2  <= '0;
            q2_s2 <= '0;
            q_s2  <= '0;
            k_s2  <= '0;
            r_s3  <= '0;
            q_s3  <= '0;
            t     <= '0;
        end else begin
            x_s1  <= prod1;
            q_s1  <= q;
            mu_s1 <= mu;
            k_s1  <= k;
            x_s2  <= x_s1[65:0];
            q2_s2 <= prod2;
            q_s2  <= q_s1;
            k_s2  <= k_s1;
            r_s3  <= r_next;
            q_s3  <= q_s2;
            t     <= r_fix2[63:0];
        end
    end
endmodule

// File: tb/tb_vedic_barrett.sv
// Bench for vedic_barrett: known vectors, small-modulus sweep, random legal
// vectors, streaming and mid-stream reset against a plain-arithmetic model.

module tb_vedic_barrett;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] a = '0, b = '0, q = '0;
    logic [30:0] mu = '0;
    logic [7:0]  k = '0;
    logic [63:0] t;

    int n_cmp = 0;
    int n_bad = 0;

    logic        vld_q[$];
    logic [63:0] exp_q[$];
    string       tag_q[$];

    typedef struct {
        logic [63:0] a, b, q;
        logic [30:0] mu;
        logic [7:0]  k;
        logic [63:0] exp;
        string       tag;
    } vec_t;
    vec_t tbl[5];

    vedic_barrett dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .q(q), .mu(mu), .k(k), .t(t)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mod(input logic [63:0] x, input logic [63:0] y,
                                            input logic [63:0] m);
        longint unsigned p;
        p = longint'(x) * longint'(y);
        return p % longint'(m);
    endfunction

    function automatic logic [30:0] ref_mu(input logic [63:0] m, input int kk);
        longint unsigned num;
        num = 64'd1 << (2 * kk);
        return 31'(num / longint'(m));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: t=%0d, required %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    // After reset the cleared stages hold all-zero operands, which can only yield 0.
    task automatic prefill();
        vld_q.delete(); exp_q.delete(); tag_q.delete();
        for (int i = 0; i < 3; i++) begin
            vld_q.push_back(1'b1); exp_q.push_back(64'd0); tag_q.push_back("fill_zero");
        end
    endtask

    task automatic step(input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vq,
                        input logic [30:0] vmu, input logic [7:0] vk,
                        input logic vv, input logic [63:0] ve, input string name);
        logic        cv;
        logic [63:0] ce;
        string       cn;
        @(negedge clk);
        a = va; b = vb; q = vq; mu = vmu; k = vk;
        @(posedge clk);
        vld_q.push_back(vv); exp_q.push_back(ve); tag_q.push_back(name);
        #1;
        cv = vld_q.pop_front(); ce = exp_q.pop_front(); cn = tag_q.pop_front();
        if (cv) check(cn, t, ce);
    endtask

    task automatic rand_legal(output logic [63:0] ra, output logic [63:0] rb,
                              output logic [63:0] rq, output logic [30:0] rmu,
                              output logic [7:0] rk);
        int          kk;
        logic [63:0] lo;
        kk  = int'($urandom_range(29, 2));
        lo  = 64'd1 << (kk - 1);
        rq  = lo + 64'($urandom) % lo;
        ra  = 64'($urandom) % rq;
        rb  = 64'($urandom) % rq;
        rmu = ref_mu(rq, kk);
        rk  = 8'(kk);
    endtask

    task automatic step_rand(input string name);
        logic [63:0] ra, rb, rq;
        logic [30:0] rmu;
        logic [7:0]  rk;
        rand_legal(ra, rb, rq, rmu, rk);
        step(ra, rb, rq, rmu, rk, 1'b1, ref_mod(ra, rb, rq), name);
    endtask

    initial begin
        tbl[0] = '{64'd146712, 64'd248912, 64'd768112, 31'd1431447, 8'd20, 64'd28528, "spec_vec"};
        tbl[1] = '{64'd0, 64'd248912, 64'd768112, 31'd1431447, 8'd20, 64'd0, "zero_a"};
        tbl[2] = '{64'd768111, 64'd768111, 64'd768112, 31'd1431447, 8'd20, 64'd1, "max_ab"};
        tbl[3] = '{64'd7, 64'd11, 64'd13, 31'd19, 8'd4, 64'd12, "small_q"};
        tbl[4] = '{64'd536870908, 64'd536870908, 64'd536870909, 31'd536870915, 8'd29, 64'd1, "k29"};

        #2;
        check("reset_t", t, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        prefill();

        // Each vector held so results must land on the 4th edge and then stay put.
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 7; j++)
                step(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].mu, tbl[i].k, 1'b1, tbl[i].exp, tbl[i].tag);

        for (int i = 0; i < 13; i++)
            for (int j = 0; j < 13; j++)
                step(64'(i), 64'(j), 64'd13, 31'd19, 8'd4, 1'b1,
                     ref_mod(64'(i), 64'(j), 64'd13), "sweep13");

        // Back-to-back distinct vectors with changing moduli.
        for (int i = 0; i < 5; i++)
            step(tbl[4-i].a, tbl[4-i].b, tbl[4-i].q, tbl[4-i].mu, tbl[4-i].k, 1'b1,
                 tbl[4-i].exp, "stream_tbl");
        for (int i = 0; i < 3; i++) step_rand("stream_rand");

        for (int i = 0; i < 1000; i++) step_rand("random");

        // Out-of-contract inputs: result unchecked, but the pipe must keep flowing.
        step(64'd5, 64'd7, 64'd0, 31'd0, 8'd0, 1'b0, 64'd0, "ooc");
        step(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 31'h7FFF_FFFF, 8'd255, 1'b0, 64'd0, "ooc");
        step(64'd100, 64'd200, 64'd13, 31'd19, 8'd4, 1'b0, 64'd0, "ooc");
        for (int i = 0; i < 8; i++) step_rand("after_ooc");

        // Mid-stream reset while all four stages hold live data.
        for (int i = 0; i < 4; i++) step_rand("pre_reset");
        #2 rst_n = 1'b0;
        #1 check("reset_async", t, 64'd0);
        @(posedge clk);
        #1 check("reset_hold", t, 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        prefill();
        for (int i = 0; i < 5; i++)
            step(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].mu, tbl[i].k, 1'b1, tbl[i].exp, "post_reset");
        for (int i = 0; i < 8; i++) step_rand("post_reset_rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
